move_scheduler: RTL and testbench
=================================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 32, the width of the step count and position.
REQ-002 SHALL have parameter PER_W, default 24, the width of the step period in clocks.
REQ-003 SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  move command offered.
REQ-006 SHALL have port cmd_ready  output  1  pending slot empty; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_dir  input  1  move direction: 1 = forward, 0 = reverse.
REQ-008 SHALL have port cmd_steps  input  CNT_W  number of steps to take, unsigned.
REQ-009 SHALL have port cmd_period  input  PER_W  clocks per step, unsigned.
REQ-010 SHALL have port abort  input  1  flush all queued and active motion.
REQ-011 SHALL have port busy  output  1  high when an active move is loaded.
REQ-012 SHALL have port step  output  1  one-cycle pulse per step taken.
REQ-013 SHALL have port dir  output  1  direction of the active move.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a move completes.
REQ-015 SHALL have port position  output  CNT_W  signed step position, two's-complement, wraps.
REQ-016 SHALL have ports phase_a1, phase_a2, phase_b1, phase_b2  output  1 each  coil drive outputs.

Function
REQ-017 SHALL hold one pending command and one active move.
REQ-018 SHALL drive cmd_ready combinationally as NOT pending-valid AND NOT RST.
REQ-019 SHALL implement FSM states IDLE and RUN, plus a LOAD step that takes one cycle.
REQ-020 SHALL transfer the pending command to the active move in IDLE; the next state is RUN.
REQ-021 SHALL, in RUN, count cmd_period clocks per step and clamp any cmd_period < 2 to 2.
REQ-022 SHALL assert the first step pulse exactly cmd_period cycles after RUN is entered.
REQ-023 SHALL, on each step pulse, update phase index (+1 if dir=1, -1 if dir=0, modulo table length), position (+/-1) and remaining count (-1).
REQ-024 SHALL register the phase outputs so they change on the same edge that step rises.
REQ-025 SHALL use the full-step table for index 0..3: a1 a2 b1 b2 = 1010, 0110, 0101, 1001.
REQ-026 SHALL pulse done on the final step's cycle, then load the pending command (if any) back-to-back with no IDLE cycle; otherwise go to IDLE.
REQ-027 SHALL, when cmd_steps = 0, pulse done one cycle after load, emit no step, and leave phase and position unchanged.
REQ-028 SHALL give abort top priority: pending and active moves are cleared next edge, the FSM goes to IDLE, no done pulse is issued, and phase outputs and position hold.
REQ-029 SHALL discard a command offered in the same cycle as abort.
REQ-030 SHALL accept a new command while RUN is active if the pending slot is empty.
REQ-031 SHALL let position wrap modulo 2^CNT_W with no flag.

Reset
REQ-032 SHALL, while RST is high, force: FSM=IDLE, pending empty, busy=step=done=dir=0, position=0, phase index 0 (outputs 1010), cmd_ready=0.
REQ-033 SHALL, when RST is asserted mid-move, drop all motion immediately without issuing done.

Configuration
REQ-034 SHALL, with HALFSTEP_EN defined, use an 8-entry half-step table: 1010, 0010, 0110, 0100, 0101, 0001, 1001, 1000.
REQ-035 SHALL, with HALFSTEP_EN undefined, use the 4-entry full-step table with a 2-bit phase index.

Verification
REQ-036 SHALL cover: reset, then cmd steps=4, dir=1, period=10 -> step pulses at RUN+10, +20, +30, +40; phases 0110, 0101, 1001, 1010; position=4; one done pulse.
REQ-037 SHALL cover: two commands queued (3 fwd, 2 rev, period=5) -> no gap between moves, position 3 then 1, two done pulses.
REQ-038 SHALL cover: cmd steps=0 -> done one cycle after load, no step pulse, phases unchanged.
REQ-039 SHALL cover: abort after 2 of 10 steps, with a pending command queued -> IDLE, busy=0, cmd_ready=1, position=2, no done pulse, no further steps.
REQ-040 SHALL cover: period=0 and period=1 -> step pulse every 2 cycles.
REQ-041 SHALL cover: HALFSTEP_EN build, 3 reverse steps from reset -> phases 1000, 1001, 0001; position = -3.

Source files
------------

// File: rtl/move_scheduler.sv
// move_scheduler: stepper-motor move sequencer.
//
// One command can wait in a pending slot while one move is active. An active
// move emits one step pulse every `period` clocks (periods below 2 are treated
// as 2), walks the coil phase table, tracks a signed wrapping position and
// pulses `done` on the cycle of its final step. A pending command is loaded
// on that same edge, so consecutive moves run with no idle cycle in between.
// `abort` clears both the active and the pending move. It holds the position
// and the phase outputs, and it issues no done pulse.
//
// Optional build macro: HALFSTEP_EN. When it is defined, an 8-entry half-step
// coil table and a 3-bit phase index are used. When it is undefined, a 4-entry
// full-step table and a 2-bit phase index are used.
//
// Handshake: a command is taken on a rising CLK edge when cmd_valid and
// cmd_ready are both high and abort is low. cmd_ready depends only on the
// pending slot being empty and on RST. It never depends on cmd_valid.
//
// state_dbg exposes the FSM state (0 = IDLE, 1 = RUN) for observation.

module move_scheduler #(
    parameter int CNT_W = 32,
    parameter int PER_W = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             busy,
    output logic             step,
    output logic             dir,
    output logic             done,
    output logic [CNT_W-1:0] position,
    output logic             phase_a1,
    output logic             phase_a2,
    output logic             phase_b1,
    output logic             phase_b2,
    output logic             state_dbg
);

`ifdef HALFSTEP_EN
    localparam int IDX_W = 3;
`else
    localparam int IDX_W = 2;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Coil pattern {a1, a2, b1, b2} for each phase index.
    function automatic logic [3:0] phase_of(input logic [IDX_W-1:0] idx);
        logic [3:0] pat;
        pat = 4'b1010;
`ifdef HALFSTEP_EN
        case (idx)
            3'd0: pat = 4'b1010;
            3'd1: pat = 4'b0010;
            3'd2: pat = 4'b0110;
            3'd3: pat = 4'b0100;
            3'd4: pat = 4'b0101;
            3'd5: pat = 4'b0001;
            3'd6: pat = 4'b1001;
            3'd7: pat = 4'b1000;
            default: pat = 4'b1010;
        endcase
`else
        case (idx)
            2'd0: pat = 4'b1010;
            2'd1: pat = 4'b0110;
            2'd2: pat = 4'b0101;
            2'd3: pat = 4'b1001;
            default: pat = 4'b1010;
        endcase
`endif
        return pat;
    endfunction

    state_t state;
    state_t state_next;

    // Pending command slot.
    logic             pend_valid;
    logic             pend_dir;
    logic [CNT_W-1:0] pend_steps;
    logic [PER_W-1:0] pend_period;

    // Active move.
    logic [CNT_W-1:0] remaining;
    logic [PER_W-1:0] act_period;
    logic [PER_W-1:0] timer;
    logic [IDX_W-1:0] phase_idx;
    logic [IDX_W-1:0] phase_idx_next;
    logic [3:0]       phase_q;

    // Decoded events for the current cycle.
    logic accept;
    logic fire;
    logic finish;
    logic load;
    logic [PER_W-1:0] pend_period_eff;

    assign cmd_ready = !pend_valid && !RST;
    assign accept    = cmd_valid && cmd_ready && !abort;

    // A step fires when the period counter reaches its last clock. A move that
    // has no steps left never fires.
    assign fire   = (state == RUN) && (remaining != '0) &&
                    (timer == act_period - PER_W'(1));

    // A move ends on its final step. A zero-step move ends on its first RUN cycle.
    assign finish = (state == RUN) &&
                    ((remaining == '0) || (fire && (remaining == CNT_W'(1))));

    // The pending command moves into the active slot from IDLE, or back-to-back
    // as the current move finishes. abort suppresses the transfer.
    assign load   = !abort && pend_valid && ((state == IDLE) || finish);

    assign pend_period_eff = (pend_period < PER_W'(2)) ? PER_W'(2) : pend_period;
    assign phase_idx_next  = dir ? (phase_idx + IDX_W'(1)) : (phase_idx - IDX_W'(1));

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic: abort wins, and a finishing move chains into a pending one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (finish) begin
                    state_next = load ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: busy means an active move is loaded.
    always_comb begin
        busy      = 1'b0;
        state_dbg = 1'b0;
        if (state == RUN) begin
            busy      = 1'b1;
            state_dbg = 1'b1;
        end
    end

    // Pending slot: filled on accept, emptied on load, flushed by abort.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_valid  <= 1'b0;
            pend_dir    <= 1'b0;
            pend_steps  <= '0;
            pend_period <= '0;
        end else if (abort) begin
            pend_valid <= 1'b0;
        end else begin
            if (load) begin
                pend_valid <= 1'b0;
            end
            if (accept) begin
                pend_valid  <= 1'b1;
                pend_dir    <= cmd_dir;
                pend_steps  <= cmd_steps;
                pend_period <= cmd_period;
            end
        end
    end

    // Active move datapath: period timer, step/done pulses, phase, position.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            remaining  <= '0;
            act_period <= PER_W'(2);
            timer      <= '0;
            dir        <= 1'b0;
            step       <= 1'b0;
            done       <= 1'b0;
            phase_idx  <= '0;
            phase_q    <= 4'b1010;
            position   <= '0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            if (abort) begin
                // Motion stops where it is. Phase and position are held.
                timer <= '0;
            end else begin
                if (fire) begin
                    step      <= 1'b1;
                    timer     <= '0;
                    remaining <= remaining - CNT_W'(1);
                    phase_idx <= phase_idx_next;
                    phase_q   <= phase_of(phase_idx_next);
                    position  <= dir ? (position + CNT_W'(1)) : (position - CNT_W'(1));
                end else if (state == RUN) begin
                    timer <= timer + PER_W'(1);
                end
                if (finish) begin
                    done <= 1'b1;
                end
                // Loading overrides the decrement of a move that just ended.
                if (load) begin
                    remaining  <= pend_steps;
                    act_period <= pend_period_eff;
                    dir        <= pend_dir;
                    timer      <= '0;
                end
            end
        end
    end

    assign phase_a1 = phase_q[3];
    assign phase_a2 = phase_q[2];
    assign phase_b1 = phase_q[1];
    assign phase_b2 = phase_q[0];

endmodule

// File: tb/tb_move_scheduler.sv
// Directed testbench for move_scheduler.
// Each scenario task drives commands and compares the recorded step cycles,
// phases, positions and done cycles with values worked out by hand.

module tb_move_scheduler;

    logic        CLK;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [31:0] cmd_steps;
    logic [23:0] cmd_period;
    logic        abort;
    logic        busy;
    logic        step;
    logic        dir;
    logic        done;
    logic [31:0] position;
    logic        phase_a1;
    logic        phase_a2;
    logic        phase_b1;
    logic        phase_b2;
    logic        state_dbg;

    logic [3:0]  ph;

    int errors;
    int checks;
    int cyc;

    int          step_cyc[$];
    logic [3:0]  step_ph[$];
    logic [31:0] step_pos[$];
    int          done_cyc[$];

    move_scheduler #(.CNT_W(32), .PER_W(24)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .abort(abort), .busy(busy), .step(step), .dir(dir), .done(done),
        .position(position), .phase_a1(phase_a1), .phase_a2(phase_a2),
        .phase_b1(phase_b1), .phase_b2(phase_b2), .state_dbg(state_dbg)
    );

    assign ph = {phase_a1, phase_a2, phase_b1, phase_b2};

    // Clock and edge counter.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Record each step pulse and each done pulse together with the edge number at which it rose.
    always @(negedge CLK) begin
        if (step) begin
            step_cyc.push_back(cyc);
            step_ph.push_back(ph);
            step_pos.push_back(position);
        end
        if (done) done_cyc.push_back(cyc);
    end

    task automatic clear_log;
        step_cyc.delete();
        step_ph.delete();
        step_pos.delete();
        done_cyc.delete();
    endtask

    task automatic do_reset;
        RST = 1'b1;
        cmd_valid = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        clear_log();
    endtask

    // Offer one command for one cycle. acc returns the edge that accepted it.
    task automatic send_cmd(input logic d, input logic [31:0] s, input logic [23:0] p,
                            output int acc);
        @(negedge CLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: cmd_ready=%b expected 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_dir = d;
        cmd_steps = s;
        cmd_period = p;
        @(negedge CLK);
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir = 1'b1;
        cmd_steps = 32'd5;
        cmd_period = 24'd3;
        abort = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({busy, step, done, dir, cmd_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/step/done/dir/ready=%b expected 00000",
                     {busy, step, done, dir, cmd_ready});
        end
        checks++;
        if (position !== 32'd0) begin
            errors++;
            $display("FAIL reset_position: got %0h expected 0", position);
        end
        checks++;
        if (ph !== 4'b1010) begin
            errors++;
            $display("FAIL reset_phase: got %b expected 1010", ph);
        end
        cmd_valid = 1'b0;
        RST = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b expected 1 0", cmd_ready, busy);
        end
        clear_log();
    endtask

    task automatic test_single_move;
        int a;
        logic [3:0] exp_ph[4];
        exp_ph[0] = 4'b0110; exp_ph[1] = 4'b0101; exp_ph[2] = 4'b1001; exp_ph[3] = 4'b1010;
        do_reset();
        send_cmd(1'b1, 32'd4, 24'd10, a);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got %b expected 1", busy);
        end
        wait_until(a + 46);
        checks++;
        if (step_cyc.size() != 4) begin
            errors++;
            $display("FAIL single_step_count: got %0d expected 4", step_cyc.size());
        end
        for (int i = 0; i < 4 && i < step_cyc.size(); i++) begin
            checks++;
            if (step_cyc[i] != a + 11 + 10 * i || step_ph[i] !== exp_ph[i] ||
                step_pos[i] !== 32'(i + 1)) begin
                errors++;
                $display("FAIL single_step%0d: cyc=%0d ph=%b pos=%0d expected cyc=%0d ph=%b pos=%0d",
                         i, step_cyc[i] - a, step_ph[i], step_pos[i], 11 + 10 * i, exp_ph[i], i + 1);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || (done_cyc.size() == 1 && done_cyc[0] != a + 41)) begin
            errors++;
            $display("FAIL single_done: count=%0d expected one pulse at accept+41", done_cyc.size());
        end
        checks++;
        if (position !== 32'd4 || busy !== 1'b0 || dir !== 1'b1) begin
            errors++;
            $display("FAIL single_final: pos=%0d busy=%b dir=%b expected 4 0 1", position, busy, dir);
        end
    endtask

    task automatic test_back_to_back;
        int a;
        int b;
        int exp_c[5];
        logic [3:0] exp_ph[5];
        logic [31:0] exp_pos[5];
        exp_c[0] = 6; exp_c[1] = 11; exp_c[2] = 16; exp_c[3] = 21; exp_c[4] = 26;
        exp_ph[0] = 4'b0110; exp_ph[1] = 4'b0101; exp_ph[2] = 4'b1001;
        exp_ph[3] = 4'b0101; exp_ph[4] = 4'b0110;
        exp_pos[0] = 1; exp_pos[1] = 2; exp_pos[2] = 3; exp_pos[3] = 2; exp_pos[4] = 1;
        do_reset();
        send_cmd(1'b1, 32'd3, 24'd5, a);
        send_cmd(1'b0, 32'd2, 24'd5, b);
        checks++;
        if (b != a + 2) begin
            errors++;
            $display("FAIL b2b_accept: second accepted at +%0d expected +2", b - a);
        end
        wait_until(a + 17);
        checks++;
        if (busy !== 1'b1 || dir !== 1'b0) begin
            errors++;
            $display("FAIL b2b_chain: busy=%b dir=%b expected 1 0", busy, dir);
        end
        wait_until(a + 32);
        checks++;
        if (step_cyc.size() != 5) begin
            errors++;
            $display("FAIL b2b_step_count: got %0d expected 5", step_cyc.size());
        end
        for (int i = 0; i < 5 && i < step_cyc.size(); i++) begin
            checks++;
            if (step_cyc[i] != a + exp_c[i] || step_ph[i] !== exp_ph[i] || step_pos[i] !== exp_pos[i]) begin
                errors++;
                $display("FAIL b2b_step%0d: cyc=%0d ph=%b pos=%0d expected cyc=%0d ph=%b pos=%0d",
                         i, step_cyc[i] - a, step_ph[i], step_pos[i], exp_c[i], exp_ph[i], exp_pos[i]);
            end
        end
        checks++;
        if (done_cyc.size() != 2 ||
            (done_cyc.size() == 2 && (done_cyc[0] != a + 16 || done_cyc[1] != a + 26))) begin
            errors++;
            $display("FAIL b2b_done: count=%0d expected 2 pulses at +16 and +26", done_cyc.size());
        end
        checks++;
        if (position !== 32'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final: pos=%0d busy=%b expected 1 0", position, busy);
        end
    endtask

    task automatic test_zero_steps;
        int a;
        do_reset();
        send_cmd(1'b1, 32'd0, 24'd7, a);
        wait_until(a + 12);
        checks++;
        if (done_cyc.size() != 1 || (done_cyc.size() == 1 && done_cyc[0] != a + 2)) begin
            errors++;
            $display("FAIL zero_done: count=%0d expected one pulse at accept+2", done_cyc.size());
        end
        checks++;
        if (step_cyc.size() != 0 || ph !== 4'b1010 || position !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_hold: steps=%0d ph=%b pos=%0d busy=%b expected 0 1010 0 0",
                     step_cyc.size(), ph, position, busy);
        end
    endtask

    task automatic test_abort;
        int a;
        int b;
        do_reset();
        send_cmd(1'b1, 32'd10, 24'd4, a);
        send_cmd(1'b1, 32'd5, 24'd3, b);
        wait_until(a + 9);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: busy=%b ready=%b expected 0 1", busy, cmd_ready);
        end
        wait_until(a + 40);
        checks++;
        if (step_cyc.size() != 2 || done_cyc.size() != 0) begin
            errors++;
            $display("FAIL abort_pulses: steps=%0d dones=%0d expected 2 0",
                     step_cyc.size(), done_cyc.size());
        end
        checks++;
        if (position !== 32'd2 || ph !== 4'b0101 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: pos=%0d ph=%b busy=%b expected 2 0101 0", position, ph, busy);
        end
        // A command offered together with abort must be dropped.
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_dir = 1'b1;
        cmd_steps = 32'd3;
        cmd_period = 24'd2;
        abort = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        abort = 1'b0;
        repeat (8) @(negedge CLK);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || position !== 32'd2) begin
            errors++;
            $display("FAIL abort_discard: ready=%b busy=%b pos=%0d expected 1 0 2",
                     cmd_ready, busy, position);
        end
    endtask

    task automatic test_short_period;
        int a;
        for (int p = 0; p < 2; p++) begin
            do_reset();
            send_cmd(1'b1, 32'd3, 24'(p), a);
            wait_until(a + 12);
            checks++;
            if (step_cyc.size() != 3) begin
                errors++;
                $display("FAIL period%0d_count: got %0d expected 3", p, step_cyc.size());
            end
            for (int i = 0; i < 3 && i < step_cyc.size(); i++) begin
                checks++;
                if (step_cyc[i] != a + 3 + 2 * i) begin
                    errors++;
                    $display("FAIL period%0d_step%0d: at +%0d expected +%0d",
                             p, i, step_cyc[i] - a, 3 + 2 * i);
                end
            end
        end
    endtask

    task automatic test_reset_mid_move;
        int a;
        do_reset();
        send_cmd(1'b1, 32'd10, 24'd3, a);
        wait_until(a + 8);
        RST = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || position !== 32'd0 || ph !== 4'b1010 || cmd_ready !== 1'b0 || step !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b pos=%0d ph=%b ready=%b step=%b expected 0 0 1010 0 0",
                     busy, position, ph, cmd_ready, step);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        checks++;
        if (step_cyc.size() != 2 || done_cyc.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: steps=%0d dones=%0d busy=%b expected 2 0 0",
                     step_cyc.size(), done_cyc.size(), busy);
        end
    endtask

    task automatic test_reverse_table;
        int a;
        logic [3:0] exp_ph[3];
`ifdef HALFSTEP_EN
        exp_ph[0] = 4'b1000; exp_ph[1] = 4'b1001; exp_ph[2] = 4'b0001;
`else
        exp_ph[0] = 4'b1001; exp_ph[1] = 4'b0101; exp_ph[2] = 4'b0110;
`endif
        do_reset();
        send_cmd(1'b0, 32'd3, 24'd2, a);
        wait_until(a + 12);
        checks++;
        if (step_cyc.size() != 3) begin
            errors++;
            $display("FAIL rev_count: got %0d expected 3", step_cyc.size());
        end
        for (int i = 0; i < 3 && i < step_ph.size(); i++) begin
            checks++;
            if (step_ph[i] !== exp_ph[i]) begin
                errors++;
                $display("FAIL rev_phase%0d: got %b expected %b", i, step_ph[i], exp_ph[i]);
            end
        end
        checks++;
        if (position !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL rev_position: got %0h expected fffffffd", position);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RST = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir = 1'b0;
        cmd_steps = '0;
        cmd_period = '0;
        abort = 1'b0;
        test_reset();
        test_single_move();
        test_back_to_back();
        test_zero_steps();
        test_abort();
        test_short_period();
        test_reset_mid_move();
        test_reverse_table();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
